store_wc_buffer: RTL and testbench

- Parametrised post-retire store write-combining buffer between ROB store retirement and data memory.
- Accepts retired stores (address, data, byte enables) and merges stores to the same word into one entry.
- Drains entries oldest-first to memory over a valid/ack handshake.
- Forwards buffered data to younger loads; successor to the single-entry wc_array scheme, adding depth, byte masks, timeout/forced drain and load forwarding.

---
 rtl/store_wc_buffer_if.sv | 30 +++
 rtl/store_wc_buffer.sv | 185 ++++++++++++++++++
 tb/tb_store_wc_buffer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/store_wc_buffer_if.sv
// Store-side and memory-side handshake bundle for the write-combining store buffer.
// The slave modport is the buffer's view; master is the view of the core/memory driving it.
interface store_wc_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [BE_W-1:0]   st_be;
  logic              st_ready;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [BE_W-1:0]   mem_wr_be;
  logic              mem_wr_ack;

  modport slave (
    input  st_valid, st_addr, st_data, st_be, mem_wr_ack,
    output st_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be
  );

  modport master (
    output st_valid, st_addr, st_data, st_be, mem_wr_ack,
    input  st_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be
  );
endinterface

// File: rtl/store_wc_buffer.sv
// Post-retire store write-combining buffer: merges same-word stores, drains oldest-first
// to memory over valid/ack, and forwards the youngest matching entry to loads.
module store_wc_buffer #(
  parameter int DEPTH           = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int DRAIN_THRESHOLD = 2,
  parameter int DRAIN_TIMEOUT   = 16,
  localparam int BE_W  = DATA_W / 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  store_wc_buffer_if.slave  bus,
  input  logic              drain_all,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [BE_W-1:0]   ld_be,
  output logic              ld_hit,
  output logic              ld_partial,
  output logic [DATA_W-1:0] ld_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OFF_W  = $clog2(BE_W);
  localparam int WA_W   = ADDR_W - OFF_W;
  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WRITE} state_t;
  state_t state_reg, state_next;

  logic [DEPTH-1:0]  ent_valid_reg;
  logic [WA_W-1:0]   ent_waddr_reg [DEPTH];
  logic [DATA_W-1:0] ent_data_reg  [DEPTH];
  logic [BE_W-1:0]   ent_be_reg    [DEPTH];
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [IDLE_W-1:0] idle_reg;

  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [BE_W-1:0]   wr_be_reg;

  logic [WA_W-1:0]   st_waddr, ld_waddr;
  logic              unused_low_bits;
  logic              go_write, head_busy, accept, alloc, merge, ack;
  logic [DEPTH-1:0]  st_match, ld_match;
  logic              st_hit, ld_any;
  logic [PTR_W-1:0]  st_idx, ld_idx, scan;
  logic [DATA_W-1:0] merged_data;
  logic [BE_W-1:0]   ld_cover;

  assign st_waddr        = bus.st_addr[ADDR_W-1:OFF_W];
  assign ld_waddr        = ld_addr[ADDR_W-1:OFF_W];
  assign unused_low_bits = ^{bus.st_addr[OFF_W-1:0], ld_addr[OFF_W-1:0]};

  assign go_write = (state_reg == S_IDLE) && (count_reg != '0) &&
                    ((count_reg >= CNT_W'(DRAIN_THRESHOLD)) || drain_all ||
                     (idle_reg == IDLE_W'(DRAIN_TIMEOUT)));
  // The head is also locked on the cycle it is being captured into mem_wr_*,
  // otherwise a merge on that edge would be lost from the outgoing write.
  assign head_busy = (state_reg == S_WRITE) || go_write;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign st_match[gi] = ent_valid_reg[gi] && (ent_waddr_reg[gi] == st_waddr) &&
                            !(head_busy && (head_reg == PTR_W'(gi)));
      assign ld_match[gi] = ent_valid_reg[gi] && (ent_waddr_reg[gi] == ld_waddr);
    end
  endgenerate

  // Scan from oldest to youngest so the last match found is the youngest.
  always_comb begin
    st_hit = 1'b0;
    st_idx = '0;
    ld_any = 1'b0;
    ld_idx = '0;
    scan   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan = head_reg + PTR_W'(k);
      if (st_match[scan]) begin
        st_hit = 1'b1;
        st_idx = scan;
      end
      if (ld_match[scan]) begin
        ld_any = 1'b1;
        ld_idx = scan;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      assign merged_data[gi*8 +: 8] = bus.st_be[gi] ? bus.st_data[gi*8 +: 8]
                                                    : ent_data_reg[st_idx][gi*8 +: 8];
    end
  endgenerate

  assign bus.st_ready = (count_reg < CNT_W'(DEPTH)) || st_hit;
  assign accept       = bus.st_valid && bus.st_ready;
  assign alloc        = accept && !st_hit;
  assign merge        = accept && st_hit;
  assign ack          = (state_reg == S_WRITE) && bus.mem_wr_ack;

  assign ld_cover   = ent_be_reg[ld_idx] & ld_be;
  assign ld_hit     = ld_any && (ld_cover == ld_be);
  assign ld_partial = ld_any && (ld_cover != ld_be);
  assign ld_data    = ld_any ? ent_data_reg[ld_idx] : '0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (go_write) state_next = S_WRITE;
      S_WRITE: if (ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_waddr_reg[i] <= '0;
        ent_data_reg[i]  <= '0;
        ent_be_reg[i]    <= '0;
      end
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      idle_reg    <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_be_reg   <= '0;
    end else begin
      if (alloc) begin
        ent_valid_reg[tail_reg] <= 1'b1;
        ent_waddr_reg[tail_reg] <= st_waddr;
        ent_data_reg[tail_reg]  <= bus.st_data;
        ent_be_reg[tail_reg]    <= bus.st_be;
        tail_reg                <= tail_reg + 1'b1;
      end
      if (merge) begin
        ent_data_reg[st_idx] <= merged_data;
        ent_be_reg[st_idx]   <= ent_be_reg[st_idx] | bus.st_be;
      end
      if (ack) begin
        ent_valid_reg[head_reg] <= 1'b0;
        head_reg                <= head_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(alloc) - CNT_W'(ack);

      if (accept || (state_reg == S_WRITE)) begin
        idle_reg <= '0;
      end else if ((count_reg != '0) && (idle_reg != IDLE_W'(DRAIN_TIMEOUT))) begin
        idle_reg <= idle_reg + 1'b1;
      end

      if (go_write) begin
        wr_en_reg   <= 1'b1;
        wr_addr_reg <= {ent_waddr_reg[head_reg], {OFF_W{1'b0}}};
        wr_data_reg <= ent_data_reg[head_reg];
        wr_be_reg   <= ent_be_reg[head_reg];
      end else if (ack) begin
        wr_en_reg <= 1'b0;
      end
    end
  end

  assign bus.mem_wr_en   = wr_en_reg;
  assign bus.mem_wr_addr = wr_addr_reg;
  assign bus.mem_wr_data = wr_data_reg;
  assign bus.mem_wr_be   = wr_be_reg;
  assign count           = count_reg;
  assign empty           = (count_reg == '0);
endmodule

// File: tb/tb_store_wc_buffer.sv
// Directed bench for store_wc_buffer (DEPTH=4, THRESHOLD=2, TIMEOUT=16): merge, threshold
// drain, backpressure, timeout, forwarding and reset during an outstanding write.
module tb_store_wc_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drain_all = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [3:0]  ld_be = '0;
  logic        ld_hit, ld_partial, empty;
  logic [31:0] ld_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  store_wc_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  store_wc_buffer #(
    .DEPTH(4), .ADDR_W(32), .DATA_W(32), .DRAIN_THRESHOLD(2), .DRAIN_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .drain_all(drain_all),
    .ld_addr(ld_addr), .ld_be(ld_be), .ld_hit(ld_hit), .ld_partial(ld_partial),
    .ld_data(ld_data), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one store for a single cycle; returns 1ns after the accepting edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_be    = be;
    #1;
    check("st_ready_on_store", 64'(bus.st_ready), 64'd1);
    step();
    bus.st_valid = 1'b0;
    $display("store addr=0x%08h data=0x%08h be=%b count=%0d", a, d, be, count);
  endtask

  // Waits (bounded) for a memory write, checks latency and payload, then acks it.
  task automatic drain_one(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input int lat);
    int n;
    n = 0;
    while (!bus.mem_wr_en && n < 40) begin
      step();
      n++;
    end
    check({tag, "_lat"},  64'(n), 64'(lat));
    check({tag, "_addr"}, 64'(bus.mem_wr_addr), 64'(a));
    check({tag, "_data"}, 64'(bus.mem_wr_data), 64'(d));
    check({tag, "_be"},   64'(bus.mem_wr_be), 64'(be));
    bus.mem_wr_ack = 1'b1;
    step();
    bus.mem_wr_ack = 1'b0;
    check({tag, "_en_drop"}, 64'(bus.mem_wr_en), 64'd0);
    $display("write addr=0x%08h data=0x%08h be=%b latency=%0d", bus.mem_wr_addr,
             bus.mem_wr_data, bus.mem_wr_be, n);
  endtask

  initial begin
    bus.st_valid   = 1'b0;
    bus.st_addr    = '0;
    bus.st_data    = '0;
    bus.st_be      = '0;
    bus.mem_wr_ack = 1'b0;

    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_ready", 64'(bus.st_ready), 64'd1);
    check("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    check("rst_wr_addr", 64'(bus.mem_wr_addr), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Two half-word stores into one word combine; drain comes from the timeout
    // (TIMEOUT+1 edges after the last accepting edge).
    store(32'h100, 32'h0000AABB, 4'b0011);
    store(32'h102, 32'hCCDD0000, 4'b1100);
    check("merge_count", 64'(count), 64'd1);
    drain_one("merge", 32'h100, 32'hCCDDAABB, 4'b1111, 17);
    check("merge_empty", 64'(empty), 64'd1);

    // Threshold: write request visible one edge after the second accept.
    store(32'h100, 32'h11111111, 4'b1111);
    store(32'h200, 32'h22222222, 4'b1111);
    check("thr_en_before", 64'(bus.mem_wr_en), 64'd0);
    step();
    check("thr_en_rise", 64'(bus.mem_wr_en), 64'd1);
    check("thr_addr0", 64'(bus.mem_wr_addr), 64'h100);
    for (int i = 0; i < 3; i++) step();
    check("thr_hold_en", 64'(bus.mem_wr_en), 64'd1);
    check("thr_hold_addr", 64'(bus.mem_wr_addr), 64'h100);
    drain_one("thr1", 32'h100, 32'h11111111, 4'b1111, 0);
    check("thr_count1", 64'(count), 64'd1);
    drain_one("thr2", 32'h200, 32'h22222222, 4'b1111, 17);
    check("thr_empty", 64'(empty), 64'd1);

    // Lone store drains purely by timeout.
    store(32'h500, 32'h00000055, 4'b1111);
    drain_one("tmo", 32'h500, 32'h00000055, 4'b1111, 17);

    // Full buffer with the head stuck in WRITE.
    store(32'h1000, 32'h11111111, 4'b1111);
    store(32'h1004, 32'h22222222, 4'b1111);
    store(32'h1008, 32'h33333333, 4'b1111);
    store(32'h100C, 32'h44444444, 4'b1111);
    check("full_count", 64'(count), 64'd4);
    check("full_wr_addr", 64'(bus.mem_wr_addr), 64'h1000);
    bus.st_addr = 32'h1010;
    #1;
    check("full_ready_new", 64'(bus.st_ready), 64'd0);
    bus.st_addr = 32'h1004;
    #1;
    check("full_ready_merge", 64'(bus.st_ready), 64'd1);
    store(32'h1004, 32'hAB000000, 4'b1000);
    check("full_merge_count", 64'(count), 64'd4);
    bus.st_addr = 32'h1000;
    #1;
    check("full_ready_head", 64'(bus.st_ready), 64'd0);
    bus.st_addr = 32'h1010;
    bus.mem_wr_ack = 1'b1;
    #1;
    check("full_ready_ack_cycle", 64'(bus.st_ready), 64'd0);
    step();
    bus.mem_wr_ack = 1'b0;
    check("full_ready_after_ack", 64'(bus.st_ready), 64'd1);
    check("full_count_after_ack", 64'(count), 64'd3);
    drain_one("full1", 32'h1004, 32'hAB222222, 4'b1111, 1);
    drain_one("full2", 32'h1008, 32'h33333333, 4'b1111, 1);
    drain_one("full3", 32'h100C, 32'h44444444, 4'b1111, 17);
    check("full_empty", 64'(empty), 64'd1);

    // Forwarding against a partial-word entry.
    store(32'h300, 32'h00001234, 4'b0011);
    ld_addr = 32'h300;
    ld_be   = 4'b0001;
    #1;
    check("fwd_hit", 64'(ld_hit), 64'd1);
    check("fwd_hit_partial", 64'(ld_partial), 64'd0);
    check("fwd_data_b0", 64'(ld_data[7:0]), 64'h34);
    ld_be = 4'b0111;
    #1;
    check("fwd_partial", 64'(ld_partial), 64'd1);
    check("fwd_partial_hit", 64'(ld_hit), 64'd0);
    ld_addr = 32'h302;
    ld_be   = 4'b0010;
    #1;
    check("fwd_low_bits_ignored", 64'(ld_data), 64'h00001234);
    ld_addr = 32'h304;
    ld_be   = 4'b0001;
    #1;
    check("fwd_miss_hit", 64'(ld_hit), 64'd0);
    check("fwd_miss_partial", 64'(ld_partial), 64'd0);
    check("fwd_miss_data", 64'(ld_data), 64'd0);
    drain_one("fwd", 32'h300, 32'h00001234, 4'b0011, 17);

    // Forced drain, same-word store behind the in-flight head, then reset mid-write.
    drain_all = 1'b1;
    store(32'h400, 32'hDEADBEEF, 4'b1111);
    step();
    check("inf_en", 64'(bus.mem_wr_en), 64'd1);
    check("inf_addr", 64'(bus.mem_wr_addr), 64'h400);
    store(32'h400, 32'h0BADF00D, 4'b1111);
    check("inf_count", 64'(count), 64'd2);
    ld_addr = 32'h400;
    ld_be   = 4'b1111;
    #1;
    check("inf_fwd_youngest", 64'(ld_data), 64'h0BADF00D);
    #1;
    rst = 1'b1;
    #1;
    check("arst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_ready", 64'(bus.st_ready), 64'd1);
    check("arst_empty", 64'(empty), 64'd1);
    step();
    rst = 1'b0;
    drain_all = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
